// File: rtl/core_fetch_ctrl.sv
// core_fetch_ctrl: instruction-fetch controller owning the PC and the I-cache valid/ack handshake.
// Define CORE_FETCH_PERF_EN to add saturating stall/redirect performance counters.
module core_fetch_ctrl #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fch_pc_stop_in,
   input  logic              fch_mux_trn_in,
   input  logic [ADDR_W-1:0] fch_trn_addr_in,
   output logic              fch_ic_req_out,
   output logic [ADDR_W-1:0] fch_ic_addr_out,
   input  logic              fch_ic_ack_in,
   input  logic [31:0]       fch_ic_rdata_in,
   output logic [ADDR_W-1:0] fch_pc_out,
   output logic [31:0]       fch_instr_out,
   output logic              fch_vld_out,
   output logic              fch_stall_dec_out
`ifdef CORE_FETCH_PERF_EN
  ,output logic [31:0]       fch_perf_stall_cnt_out,
   output logic [31:0]       fch_perf_redir_cnt_out
`endif
);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, FLUSH = 2'd3;
   localparam logic [ADDR_W-1:0] RST_PC = {RESET_PC[ADDR_W-1:2], 2'b00};
   logic [1:0]        state;
   logic [ADDR_W-1:0] pc, flush_addr;
   logic [31:0]       buf_word;
   logic              ack;
   assign fch_ic_req_out    = (state == REQ) | (state == FLUSH);
   assign ack               = fch_ic_req_out & fch_ic_ack_in;
   // A flushed request keeps its original address while pc already tracks the redirect target.
   assign fch_ic_addr_out   = (state == FLUSH) ? flush_addr : pc;
   assign fch_stall_dec_out = ((state == REQ) & ~fch_ic_ack_in) | (state == FLUSH);
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         pc            <= RST_PC;
         flush_addr    <= RST_PC;
         buf_word      <= NOP_INSTR;
         fch_pc_out    <= RST_PC;
         fch_instr_out <= NOP_INSTR;
         fch_vld_out   <= 1'b0;
      end else if (fch_mux_trn_in) begin
         pc            <= {fch_trn_addr_in[ADDR_W-1:2], 2'b00};
         fch_vld_out   <= 1'b0;
         fch_instr_out <= NOP_INSTR;
         buf_word      <= NOP_INSTR;
         state         <= (fch_ic_req_out & ~ack) ? FLUSH : REQ;
         if (state == REQ && !ack)
            flush_addr <= pc;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (ack && fch_pc_stop_in) begin
                  buf_word <= fch_ic_rdata_in;
                  state    <= HOLD;
               end else if (ack) begin
                  fch_pc_out    <= pc;
                  fch_instr_out <= fch_ic_rdata_in;
                  fch_vld_out   <= 1'b1;
                  pc            <= pc + ADDR_W'(4);
               end else if (!fch_pc_stop_in) begin
                  fch_vld_out   <= 1'b0;
                  fch_instr_out <= NOP_INSTR;
               end
            end
            HOLD: begin
               if (!fch_pc_stop_in) begin
                  fch_pc_out    <= pc;
                  fch_instr_out <= buf_word;
                  fch_vld_out   <= 1'b1;
                  pc            <= pc + ADDR_W'(4);
                  state         <= REQ;
               end
            end
            default: state <= ack ? REQ : FLUSH;
         endcase
      end
   end
`ifdef CORE_FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fch_perf_stall_cnt_out <= '0;
         fch_perf_redir_cnt_out <= '0;
      end else begin
         fch_perf_stall_cnt_out <= fch_perf_stall_cnt_out + 32'(fch_stall_dec_out & ~&fch_perf_stall_cnt_out);
         fch_perf_redir_cnt_out <= fch_perf_redir_cnt_out + 32'(fch_mux_trn_in & ~&fch_perf_redir_cnt_out);
      end
   end
`endif
endmodule
